// File: rtl/rformat_exec_ctrl.sv
// R-format execute controller: 32x32 register file, decode, ALU, writeback sequencing.
// Latency: accept at edge N, done/wb_en in cycle N+3, idle again in cycle N+4; illegal pulses in N+2.
// Backpressure: instr_ready only in IDLE while no preload write is requested; one instruction in flight.
module rformat_exec_ctrl (
    input  logic        clk,
    input  logic        reset_input,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        ILLEGAL   = 3'd4
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] rf_q [32];

    logic        accept;
    logic        funct_ok;
    logic [2:0]  funct_alu_op;
    logic [31:0] alu_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        unused_shamt;

    // shamt has no effect on any supported operation
    assign unused_shamt = ^instr_in[10:6];

    assign instr_ready = (state_q == IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == WRITEBACK);
    assign illegal     = (state_q == ILLEGAL);
    assign wb_en       = (state_q == WRITEBACK) && (rd_q != 5'd0);
    assign wb_addr     = rd_q;
    assign wb_data     = wb_data_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

    always_comb begin
        funct_ok     = 1'b1;
        funct_alu_op = ALU_ADD;
        case (funct_q)
            6'h20:   funct_alu_op = ALU_ADD;
            6'h22:   funct_alu_op = ALU_SUB;
            6'h24:   funct_alu_op = ALU_AND;
            6'h25:   funct_alu_op = ALU_OR;
            6'h2A:   funct_alu_op = ALU_SLT;
            default: funct_ok     = 1'b0;
        endcase
    end

    // ADD/SUB wrap; SLT compares as two's complement
    always_comb begin
        alu_res = 32'd0;
        case (alu_op_q)
            ALU_ADD: alu_res = op_a_q + op_b_q;
            ALU_SUB: alu_res = op_a_q - op_b_q;
            ALU_AND: alu_res = op_a_q & op_b_q;
            ALU_OR:  alu_res = op_a_q | op_b_q;
            ALU_SLT: alu_res = {31'd0, $signed(op_a_q) < $signed(op_b_q)};
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        funct_d   = funct_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        alu_op_d  = alu_op_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opcode_d = instr_in[31:26];
                    rs_d     = instr_in[25:21];
                    rt_d     = instr_in[20:16];
                    rd_d     = instr_in[15:11];
                    funct_d  = instr_in[5:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if ((opcode_q != 6'd0) || !funct_ok) begin
                    state_d = ILLEGAL;
                end else begin
                    op_a_d   = rf_q[rs_q];
                    op_b_d   = rf_q[rt_q];
                    alu_op_d = funct_alu_op;
                    state_d  = EXECUTE;
                end
            end
            EXECUTE: begin
                wb_data_d = alu_res;
                state_d   = WRITEBACK;
            end
            WRITEBACK: state_d = IDLE;
            ILLEGAL:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Preload and writeback can never collide: preload is only honoured in IDLE
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if ((state_q == IDLE) && ld_en && (ld_addr != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = ld_addr;
            rf_wdata = ld_data;
        end else if ((state_q == WRITEBACK) && (rd_q != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            state_q   <= IDLE;
            opcode_q  <= 6'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            funct_q   <= 6'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            alu_op_q  <= 3'd0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            funct_q   <= funct_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            alu_op_q  <= alu_op_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_rformat_exec_ctrl.sv
// Randomized bench for rformat_exec_ctrl against a register-array reference model.
module tb_rformat_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset_input;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy, done, illegal, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rf [32];

    always #5 clk = ~clk;

    rformat_exec_ctrl dut (
        .clk(clk), .reset_input(reset_input),
        .instr_valid(instr_valid), .instr_in(instr_in), .instr_ready(instr_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .done(done), .illegal(illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        case (funct)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] ins);
        logic [5:0] f;
        f = ins[5:0];
        return (ins[31:26] == 6'd0) &&
               (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        logic [4:0] shamt;
        shamt = 5'($urandom);
        return {6'd0, rs, rt, rd, shamt, funct};
    endfunction

    task automatic check_dbg(input logic [4:0] addr, input string tag);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, model_rf[addr]);
    endtask

    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        if (addr != 5'd0) model_rf[addr] = data;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] ins, input bit poke_ld);
        logic [4:0]  rd;
        logic [31:0] want;
        bit          ok;
        rd   = ins[15:11];
        ok   = ref_legal(ins);
        want = ref_alu(ins[5:0], model_rf[ins[25:21]], model_rf[ins[20:16]]);
        wait_ready();
        instr_valid = 1'b1;
        instr_in    = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_in    = $urandom;
        if (poke_ld) begin
            ld_en   = 1'b1;
            ld_addr = 5'($urandom_range(1, 31));
            ld_data = $urandom;
        end
        @(negedge clk);
        chk("dec_busy", {31'd0, busy}, 32'd1);
        chk("dec_done", {31'd0, done}, 32'd0);
        chk("dec_illegal", {31'd0, illegal}, 32'd0);
        chk("dec_ready", {31'd0, instr_ready}, 32'd0);
        ld_en = 1'b0;
        @(negedge clk);
        if (!ok) begin
            chk("ill_pulse", {31'd0, illegal}, 32'd1);
            chk("ill_done", {31'd0, done}, 32'd0);
            chk("ill_wb_en", {31'd0, wb_en}, 32'd0);
            @(negedge clk);
            chk("ill_once", {31'd0, illegal}, 32'd0);
            chk("ill_no_done", {31'd0, done}, 32'd0);
            chk("ill_ready", {31'd0, instr_ready}, 32'd1);
            check_dbg(rd, "ill_reg_kept");
        end else begin
            chk("ex_done", {31'd0, done}, 32'd0);
            chk("ex_illegal", {31'd0, illegal}, 32'd0);
            @(negedge clk);
            chk("wb_done", {31'd0, done}, 32'd1);
            chk("wb_en", {31'd0, wb_en}, {31'd0, rd != 5'd0});
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
            chk("wb_data", wb_data, want);
            chk("wb_illegal", {31'd0, illegal}, 32'd0);
            if (rd != 5'd0) model_rf[rd] = want;
            @(negedge clk);
            chk("post_done", {31'd0, done}, 32'd0);
            chk("post_wb_en", {31'd0, wb_en}, 32'd0);
            chk("post_ready", {31'd0, instr_ready}, 32'd1);
            check_dbg(rd, "dbg_result");
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_instr();
        logic [5:0] ftab [5];
        logic [31:0] ins;
        ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24; ftab[3] = 6'h25; ftab[4] = 6'h2A;
        ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom), ftab[$urandom_range(0, 4)]);
        if ($urandom_range(0, 9) == 0) ins[5:0] = 6'($urandom);
        if ($urandom_range(0, 15) == 0) ins[31:26] = 6'($urandom_range(1, 63));
        issue(ins, $urandom_range(0, 3) == 0);
    endtask

    initial begin
        int pulses;
        reset_input = 1'b0;
        instr_valid = 1'b0;
        instr_in    = 32'd0;
        ld_en       = 1'b0;
        ld_addr     = 5'd0;
        ld_data     = 32'd0;
        dbg_addr    = 5'd0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_input = 1'b1;
        check_dbg(5'd17, "rst_reg17");

        // ADD 5+7 into r3
        load(5'd1, 32'd5);
        load(5'd2, 32'd7);
        issue(32'h0022_1820, 1'b0);
        // SUB 0-1, then SLT of the result against r2, then OR of the same pair
        load(5'd1, 32'd0);
        load(5'd2, 32'd1);
        issue(32'h0022_2022, 1'b0);
        issue(32'h0082_282A, 1'b0);
        issue(32'h0082_2825, 1'b0);
        // illegal opcode and illegal funct
        issue(32'h2022_1820, 1'b0);
        issue(32'h0022_1803, 1'b0);
        // rd=0 retires without a write; r0 stays zero even after a preload attempt
        issue(32'h0022_0020, 1'b0);
        load(5'd0, 32'hDEAD_BEEF);
        check_dbg(5'd0, "r0_zero");
        // rd overlapping rs/rt uses the old operands
        load(5'd6, 32'd10);
        issue(mk_r(5'd6, 5'd6, 5'd6, 6'h20), 1'b0);
        // preload and instr_valid together: load wins, no accept
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'd9; ld_data = 32'h1234_5678;
        instr_valid = 1'b1; instr_in = 32'h0022_1820;
        #1;
        chk("ld_blocks_ready", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        instr_valid = 1'b0;
        model_rf[9] = 32'h1234_5678;
        @(negedge clk);
        chk("ld_no_accept", {31'd0, busy}, 32'd0);
        check_dbg(5'd9, "ld_value");
        // signed overflow wraps; SLT sees the positive value
        load(5'd1, 32'h7FFF_FFFF);
        load(5'd2, 32'd1);
        issue(32'h0022_1820, 1'b0);
        issue(32'h0022_282A, 1'b0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 2) == 0) load(5'($urandom), rand_val());
            random_instr();
        end
        for (int r = 0; r < 32; r++) check_dbg(5'(r), "final_rf");

        // reset dropped while the instruction is in EXECUTE
        wait_ready();
        instr_valid = 1'b1;
        instr_in    = 32'h0022_1820;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_input = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wb_en", {31'd0, wb_en}, 32'd0);
        chk("abort_wb_data", wb_data, 32'd0);
        chk("abort_wb_addr", {27'd0, wb_addr}, 32'd0);
        check_dbg(5'd1, "abort_r1");
        @(negedge clk);
        reset_input = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || wb_en || busy) pulses++;
        end
        chk("abort_no_retire", pulses, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        check_dbg(5'd3, "abort_r3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
